alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; power of two, 8..64.
REQ-002 Derived constant SHW = log2(WIDTH): shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  request; sampled only when busy_o=0.
REQ-006 ALU_Operation_i  input  4  operation code, per REQ-011.
REQ-007 A_i  input  WIDTH  operand A, signed or unsigned per op.
REQ-008 B_i  input  WIDTH  operand B, signed or unsigned per op.
REQ-009 busy_o  output  1  high while an operation is in flight; new starts ignored.
REQ-010 done_o, ALU_Result_o[WIDTH], Zero_o  outputs  done_o: 1-cycle pulse when result valid; ALU_Result_o and Zero_o registered, held until next done_o.

Function
REQ-011 Codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SRA, 0111 SLT, 1000 LUI (result=B), 1001 OR, 1010 SLTU, 1011 MUL (low WIDTH bits), 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
REQ-012 FSM states IDLE, CALC, DONE; IDLE->DONE on start_i with codes 0000-1010; IDLE->CALC on start_i with codes 1011-1111; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-013 Operands and opcode captured at start acceptance; input changes afterwards have no effect on the result.
REQ-014 Single-cycle ops: done_o asserts exactly 2 clocks after the accepting edge (edge 1: latch, edge 2: DONE state); busy_o high during that interval.
REQ-015 MUL/DIV/REM ops: one iteration per clock (shift-add multiply, restoring divide); done_o asserts WIDTH+2 clocks after the accepting edge.
REQ-016 Arithmetic modulo 2^WIDTH; ADD/SUB overflow wraps, no flag.
REQ-017 Shifts use B[SHW-1:0] only; SRA replicates A[WIDTH-1].
REQ-018 SLT signed compare, SLTU unsigned; result 1 or 0 zero-extended.
REQ-019 DIV/REM: signed, quotient truncates toward zero, remainder takes dividend sign; sign fix-up applied to magnitudes after iteration.
REQ-020 Divide by zero: quotient all-ones, remainder = A; no trap; same latency as REQ-015.
REQ-021 Signed overflow (A = most-negative, B = -1): DIV result = A, REM result = 0.
REQ-022 Zero_o = (ALU_Result_o == 0), updated in the same cycle as ALU_Result_o.
REQ-023 start_i while busy_o=1 is dropped, not queued; start_i in the DONE cycle is also dropped.
REQ-024 done_o never asserts without a preceding accepted start_i.

Reset
REQ-025 reset low asynchronously forces IDLE; busy_o=0, done_o=0, ALU_Result_o=0, Zero_o=1; iteration counter and datapath registers cleared.
REQ-026 reset asserted mid-CALC aborts the operation; no done_o follows release.
REQ-027 First start_i accepted on the first rising edge after reset deasserts.

Structure
REQ-028 Opcode localparams, FSM state encodings and WIDTH default live in shared package alu_pkg, reused by the decoder.
REQ-029 Iterative multiply/divide datapath is sub-module mdu_iter (counter, accumulator, sign fix-up); alu_mdu holds FSM, single-cycle ops and output registers.

Verification
REQ-030 Reset release, ADD A=5 B=7 -> done_o 2 clocks later, result 12, Zero_o=0; SUB 7-7 -> 0, Zero_o=1.
REQ-031 SRA A=0x80000000 B=0x24 (shift 4) -> 0xF8000000; SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0.
REQ-032 MUL A=0xFFFFFFFF B=3 -> done_o after 34 clocks, result 0xFFFFFFFD; start_i pulsed mid-CALC ignored, exactly one done_o.
REQ-033 DIV -7/2 -> 0xFFFFFFFD, REM -7%2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF, REMU 7%0 -> 7.
REQ-034 DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0, Zero_o=1.
REQ-035 reset low at iteration 10 of DIVU -> outputs cleared immediately, no done_o after release; WIDTH=8 build: MUL 0x10*0x10 -> 0x00, Zero_o=1, done after 10 clocks.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and default width for the ALU/MDU block.
// The decoder and the iterative multiply/divide unit both import this package.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_LUI  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REM  = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Every code from MUL upward goes through the iterative unit.
  function automatic logic is_mdu_op(input logic [3:0] op);
    return op >= OP_MUL;
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between a requester and the ALU/MDU.
interface alu_mdu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start_i;
  logic [3:0]       ALU_Operation_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] ALU_Result_o;
  logic             Zero_o;

  modport master (
    output start_i, ALU_Operation_i, A_i, B_i,
    input  busy_o, done_o, ALU_Result_o, Zero_o
  );

  modport slave (
    input  start_i, ALU_Operation_i, A_i, B_i,
    output busy_o, done_o, ALU_Result_o, Zero_o
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply (shift-add) and divide (restoring) unit, one step per clock.
// Signed divides run on magnitudes; the sign fix-up is applied to the final result.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             mul_q, rem_q, q_neg_q, r_neg_q;

  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;

  assign sgn   = (op_i == OP_DIV) || (op_i == OP_REM);
  assign a_neg = sgn & a_i[WIDTH-1];
  assign b_neg = sgn & b_i[WIDTH-1];
  assign a_mag = a_neg ? ('0 - a_i) : a_i;
  assign b_mag = b_neg ? ('0 - b_i) : b_i;

  // x holds the multiplier (shifting right) or the dividend turning into the quotient.
  assign rem_sh = {acc_q, x_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, y_q};

  assign last_o = step_i && (cnt_q == SHW'(WIDTH - 1));

  always_comb begin
    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    cnt_d = cnt_q;
    if (load_i) begin
      acc_d = '0;
      cnt_d = '0;
      x_d   = (op_i == OP_MUL) ? b_i : a_mag;
      y_d   = (op_i == OP_MUL) ? a_i : b_mag;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (mul_q) begin
        if (x_q[0]) acc_d = acc_q + y_q;
        y_d = y_q << 1;
        x_d = x_q >> 1;
      end else if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      rem_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
      if (load_i) begin
        mul_q   <= (op_i == OP_MUL);
        rem_q   <= (op_i == OP_REM) || (op_i == OP_REMU);
        // A zero divisor keeps the all-ones quotient; the remainder fix-up restores A.
        q_neg_q <= (a_neg ^ b_neg) & (|b_i);
        r_neg_q <= a_neg;
      end
    end
  end

  always_comb begin
    if (mul_q)      result_o = acc_q;
    else if (rem_q) result_o = r_neg_q ? ('0 - acc_q) : acc_q;
    else            result_o = q_neg_q ? ('0 - x_q) : x_q;
  end

endmodule

// File: rtl/alu_mdu.sv
// ALU with iterative multiply/divide: request FSM, single-cycle operations and
// registered result/zero/done outputs. Long operations are delegated to mdu_iter.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic      clk,
  input  logic      reset,
  alu_mdu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  state_e                  state_q, state_d;
  logic [3:0]              op_q;
  logic [WIDTH-1:0]        a_q, b_q;
  logic [WIDTH-1:0]        res_q, res_d;
  logic                    zero_q, zero_d;
  logic                    done_q, done_d;

  logic                    accept, mdu_last;
  logic [WIDTH-1:0]        alu_res, mdu_res, fin_res;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [SHW-1:0]          shamt;

  assign accept = (state_q == ST_IDLE) && bus.start_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start_i) state_d = is_mdu_op(bus.ALU_Operation_i) ? ST_CALC : ST_DONE;
      ST_CALC: if (mdu_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept && is_mdu_op(bus.ALU_Operation_i)),
    .step_i   (state_q == ST_CALC),
    .op_i     (bus.ALU_Operation_i),
    .a_i      (bus.A_i),
    .b_i      (bus.B_i),
    .last_o   (mdu_last),
    .result_o (mdu_res)
  );

  assign a_s   = a_q;
  assign b_s   = b_q;
  assign shamt = b_q[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLL:  alu_res = a_q << shamt;
      OP_SRL:  alu_res = a_q >> shamt;
      OP_SRA:  alu_res = a_s >>> shamt;
      OP_SLT:  alu_res[0] = a_s < b_s;
      OP_LUI:  alu_res = b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_SLTU: alu_res[0] = a_q < b_q;
      default: alu_res = '0;
    endcase
  end

  assign fin_res = is_mdu_op(op_q) ? mdu_res : alu_res;

  // Result and zero flag load together in the DONE cycle and hold until the next one.
  always_comb begin
    res_d  = res_q;
    zero_d = zero_q;
    done_d = 1'b0;
    if (state_q == ST_DONE) begin
      res_d  = fin_res;
      zero_d = (fin_res == '0);
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      if (accept) begin
        op_q <= bus.ALU_Operation_i;
        a_q  <= bus.A_i;
        b_q  <= bus.B_i;
      end
    end
  end

  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.done_o       = done_q;
  assign bus.ALU_Result_o = res_q;
  assign bus.Zero_o       = zero_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: a 32-bit instance for most vectors and an 8-bit instance
// for the narrow-width cases, sharing clock and reset.
module tb_alu_mdu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(32)) bus ();
  alu_mdu_if #(.WIDTH(8))  bus8 ();

  alu_mdu #(.WIDTH(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
  alu_mdu #(.WIDTH(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic s, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      bus8.start_i = s; bus8.ALU_Operation_i = op; bus8.A_i = a[7:0]; bus8.B_i = b[7:0];
    end else begin
      bus.start_i = s; bus.ALU_Operation_i = op; bus.A_i = a; bus.B_i = b;
    end
  endtask

  // Issue one request, scramble inputs after acceptance, and watch a bounded window.
  task automatic run_op(input string tag, input bit w8, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int pulse_n);
    int   first = 0;
    int   dones = 0;
    logic busy1 = 1'b0;
    logic [31:0] res;
    logic zf, ez;
    @(negedge clk);
    drive(w8, 1'b1, op, a, b);
    @(posedge clk);
    #1;
    drive(w8, 1'b0, ~op, ~a, a ^ b ^ 32'h5a5a_5a5a);
    for (int n = 1; n <= lat + 6; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = w8 ? bus8.busy_o : bus.busy_o;
      if (w8 ? bus8.done_o : bus.done_o) begin
        dones++;
        if (first == 0) first = n;
      end
      if (w8) bus8.start_i = (n == pulse_n);
      else    bus.start_i  = (n == pulse_n);
    end
    drive(w8, 1'b0, ~op, ~a, a ^ b ^ 32'h5a5a_5a5a);
    res = w8 ? {24'h0, bus8.ALU_Result_o} : bus.ALU_Result_o;
    zf  = w8 ? bus8.Zero_o : bus.Zero_o;
    ez  = w8 ? (exp[7:0] == 8'h00) : (exp == 32'h0);
    chk({tag, "_busy"},  64'(busy1), 64'd1);
    chk({tag, "_lat"},   64'(first), 64'(lat));
    chk({tag, "_ndone"}, 64'(dones), 64'd1);
    chk({tag, "_res"},   64'(res),   64'(exp));
    chk({tag, "_zero"},  64'(zf),    64'(ez));
  endtask

  initial begin
    int dones;
    reset = 1'b0;
    drive(1'b0, 1'b0, OP_ADD, 32'h0, 32'h0);
    drive(1'b1, 1'b0, OP_ADD, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_res",  64'(bus.ALU_Result_o), 64'd0);
    chk("rst_zero", 64'(bus.Zero_o), 64'd1);
    chk("rst8_zero", 64'(bus8.Zero_o), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;

    run_op("add",      1'b0, OP_ADD,  32'd5,         32'd7,         32'd12,        2, 0);
    run_op("sub",      1'b0, OP_SUB,  32'd7,         32'd7,         32'd0,         2, 1);
    run_op("add_wrap", 1'b0, OP_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,         2, 0);
    run_op("and",      1'b0, OP_AND,  32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 2, 0);
    run_op("xor",      1'b0, OP_XOR,  32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'hCCCC_CCCC, 2, 0);
    run_op("or",       1'b0, OP_OR,   32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'hFCFC_FCFC, 2, 0);
    run_op("sll",      1'b0, OP_SLL,  32'd1,         32'h21,        32'd2,         2, 0);
    run_op("srl",      1'b0, OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 2, 0);
    run_op("sra",      1'b0, OP_SRA,  32'h8000_0000, 32'h24,        32'hF800_0000, 2, 0);
    run_op("slt",      1'b0, OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         2, 0);
    run_op("sltu",     1'b0, OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         2, 0);
    run_op("lui",      1'b0, OP_LUI,  32'h0000_1234, 32'hABCD_0000, 32'hABCD_0000, 2, 0);

    run_op("mul",      1'b0, OP_MUL,  32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 34, 10);
    run_op("mul_neg",  1'b0, OP_MUL,  32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 34, 0);
    run_op("div",      1'b0, OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
    run_op("rem",      1'b0, OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("div_nd",   1'b0, OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0);
    run_op("rem_nd",   1'b0, OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         34, 0);
    run_op("divu_z",   1'b0, OP_DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF, 34, 0);
    run_op("remu_z",   1'b0, OP_REMU, 32'd7,         32'd0,         32'd7,         34, 0);
    run_op("div_z",    1'b0, OP_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, 34, 0);
    run_op("rem_z",    1'b0, OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 34, 0);
    run_op("div_ovf",  1'b0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
    run_op("rem_ovf",  1'b0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, 0);
    run_op("divu_big", 1'b0, OP_DIVU, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 34, 0);
    run_op("divu",     1'b0, OP_DIVU, 32'd100,       32'd7,         32'd14,        34, 0);
    run_op("remu",     1'b0, OP_REMU, 32'd100,       32'd7,         32'd2,         34, 0);

    // Abort a DIVU after ten iterations; the previous nonzero result must clear at once.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_DIVU, 32'd100, 32'd7);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, OP_ADD, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy_o), 64'd0);
    chk("abort_done", 64'(bus.done_o), 64'd0);
    chk("abort_res",  64'(bus.ALU_Result_o), 64'd0);
    chk("abort_zero", 64'(bus.Zero_o), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_op("post_rst_add", 1'b0, OP_ADD, 32'd3, 32'd4, 32'd7, 2, 0);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);

    run_op("w8_mul",  1'b1, OP_MUL, 32'h10, 32'h10, 32'h00, 10, 0);
    run_op("w8_div",  1'b1, OP_DIV, 32'h80, 32'hFF, 32'h80, 10, 0);
    run_op("w8_sub",  1'b1, OP_SUB, 32'h03, 32'h05, 32'hFE, 2,  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
